// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage and the ALU datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_RSV = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_NOT = 3'd6,
    OP_SHL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/alu_iter_shifter.sv
// Iterative one-bit-per-cycle left shifter; done flags an exhausted count.
module alu_iter_shifter #(
  parameter int bits = 8,
  parameter int SHW  = $clog2(bits)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [bits-1:0] load_value,
  input  logic [SHW-1:0]  load_count,
  input  logic            step,
  output logic [bits-1:0] value,
  output logic            done
);

  logic [bits-1:0] value_q, value_d;
  logic [SHW-1:0]  count_q, count_d;

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (load) begin
      value_d = load_value;
      count_d = load_count;
    end else if (step) begin
      value_d = value_q << 1;
      count_d = count_q - SHW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value = value_q;
  assign done  = (count_q == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the ALU datapath; performs shl itself over several cycles.
// Optional signed-overflow output enabled by ALU_ISSUE_OVF_EN.
//   state | meaning
//   IDLE  | ready for a command
//   EXEC  | ALU operands presented, result captured at end of cycle
//   SHIFT | iterative shift in progress
//   DONE  | result held until downstream accepts
module alu_issue_stage #(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] in_a,
  input  logic [bits-1:0] in_b,
  input  logic [2:0]      in_op,
  output logic [bits-1:0] alu_a,
  output logic [bits-1:0] alu_b,
  output logic [2:0]      alu_op,
  input  logic [bits-1:0] alu_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] out_x,
  output logic            out_zero,
  output logic            out_neg,
`ifdef ALU_ISSUE_OVF_EN
  output logic            out_ovf,
`endif
  output logic            out_err
);
  import alu_pkg::*;

  localparam int SHW = $clog2(bits);

  issue_state_e    state_q, state_d;
  logic [bits-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_q, res_d;
  alu_op_e         alu_op_q, alu_op_d;
  logic            err_q, err_d;
  logic            sh_load, sh_step, sh_done;
  logic [bits-1:0] sh_value;

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    err_d    = err_q;
    sh_load  = 1'b0;
    sh_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_a_d  = in_a;
          alu_b_d  = in_b;
          alu_op_d = alu_op_e'(in_op);
          if (alu_op_e'(in_op) == OP_SHL) begin
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (alu_op_q == OP_RSV) begin
          res_d = '0;
          err_d = 1'b1;
        end else begin
          res_d = alu_x;
        end
        state_d = DONE;
      end
      SHIFT: begin
        if (sh_done) state_d = DONE;
        else         sh_step = 1'b1;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  alu_iter_shifter #(.bits(bits), .SHW(SHW)) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (sh_load),
    .load_value (in_a),
    .load_count (in_b[SHW-1:0]),
    .step       (sh_step),
    .value      (sh_value),
    .done       (sh_done)
  );

`ifdef ALU_ISSUE_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == EXEC) begin
      case (alu_op_q)
        OP_ADD:  ovf_d = (alu_a_q[bits-1] == alu_b_q[bits-1]) && (alu_x[bits-1] != alu_a_q[bits-1]);
        OP_SUB:  ovf_d = (alu_a_q[bits-1] != alu_b_q[bits-1]) && (alu_x[bits-1] != alu_a_q[bits-1]);
        default: ovf_d = 1'b0;
      endcase
    end else if (state_q == DONE && out_ready) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

  // Shift results live in the shifter; everything else in the captured result register.
  assign out_x     = (alu_op_q == OP_SHL) ? sh_value : res_q;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_zero  = out_valid && (out_x == '0);
  assign out_neg   = out_valid && out_x[bits-1];
  assign out_err   = err_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;

endmodule
